mstage_lsu: RTL
===============

MSTAGE_LSU -- requirements
Module: mstage_lsu

Interface
REQ-001 SHALL have the following ports; reset rst, synchronous, active-high; clock clk.
 clk  in  1  clock, all state updates on rising edge
 rst  in  1  synchronous active-high reset
 s_valid  in  1  upstream X-stage bundle valid
 s_ready  out  1  block can accept a bundle
 alu_res  in  32  ALU result: memory address, or writeback value for non-memory ops
 wdata  in  32  store data (src2)
 mvalid  in  1  bundle is a memory access
 mwen  in  1  1=store, 0=load (meaningful only when mvalid=1)
 mwmask  in  8  store byte mask, bus-aligned at lane 0
 mrtype  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
 rd  in  5  destination register
 mem_req_valid  out  1  memory request valid
 mem_req_ready  in  1  memory accepts request
 mem_addr  out  32  request address
 mem_wen  out  1  request is a write
 mem_wmask  out  8  lane-shifted byte mask
 mem_wdata  out  64  lane-shifted write data
 mem_rsp_valid  in  1  read data / write acknowledge valid
 mem_rdata  in  64  read data
 m_valid  out  1  writeback bundle valid
 m_ready  in  1  writeback stage accepts
 res_out  out  32  writeback value
 rd_out  out  5  writeback register; 0 for stores

Function
REQ-002 SHALL implement states IDLE, REQ, WAIT, OUT; s_ready = (state==IDLE); m_valid = (state==OUT); mem_req_valid = (state==REQ).
REQ-003 IDLE: on s_valid, SHALL capture all inputs; mvalid=1 -> REQ; else res_out<=alu_res, rd_out<=rd -> OUT.
REQ-004 REQ: mem_addr, mem_wen, mem_wmask, mem_wdata SHALL stay stable until mem_req_ready=1; then -> WAIT.
REQ-005 REQ with mem_req_ready=1 and mem_rsp_valid=1 in the same cycle SHALL complete the access directly (-> OUT), skipping WAIT.
REQ-006 WAIT: on mem_rsp_valid -> OUT; load: res_out<=extended data, rd_out<=captured rd; store: res_out<=0, rd_out<=0.
REQ-007 OUT: res_out/rd_out SHALL hold stable while m_ready=0; on m_ready -> IDLE. No acceptance during OUT (no back-to-back overlap).
REQ-008 lane = alu_res[2:0]; mem_wmask = mwmask << lane (truncated to 8 bits); mem_wdata = {32'b0,wdata} << (8*lane), truncated to 64 bits; mem_addr = alu_res unmodified.
REQ-009 load data = mem_rdata >> (8*lane), low bits taken; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW takes low 32; undefined mrtype codes SHALL behave as LW.
REQ-010 Accesses crossing an 8-byte boundary SHALL be issued as one request with truncated mask/data; no exception raised.
REQ-011 mem_rsp_valid in IDLE or OUT SHALL be ignored.
REQ-012 Minimum latency: non-memory bundle m_valid 1 cycle after accept; memory with zero-wait responder, 2 cycles.

Reset
REQ-013 On rst: state<=IDLE, res_out<=0, rd_out<=0, captured fields<=0; s_ready=1, m_valid=0, mem_req_valid=0 from the first cycle after reset.
REQ-014 rst asserted in REQ/WAIT/OUT SHALL abandon the transaction; a late mem_rsp_valid is then ignored (REQ-011).

Structure
REQ-015 Shared package xstage_pkg SHALL hold the state encoding and mrtype constants.
REQ-016 Lane shift + sign/zero extension SHALL be one combinational sub-module, load_align.

Verification
REQ-017 Non-mem: alu_res=0x1234, rd=5, m_ready=1 -> m_valid 1 cycle later, res_out=0x1234, rd_out=5.
REQ-018 LB addr 0x80000003, mem_rdata byte3=0x80 -> res_out=0xFFFFFF80; LBU -> 0x00000080.
REQ-019 SW addr 0x80000004, wdata=0xDEADBEEF, mwmask=0x0F -> mem_wmask=0xF0, mem_wdata=0xDEADBEEF_00000000, rd_out=0.
REQ-020 mem_req_ready low 3 cycles -> request fields stable; m_ready low 4 cycles -> res_out stable, s_ready=0.
REQ-021 Same-cycle mem_req_ready+mem_rsp_valid -> OUT next cycle; rst during WAIT -> IDLE, later mem_rsp_valid produces no m_valid.

Source files
------------

// File: rtl/xstage_pkg.sv
// Shared definitions for the X/M-stage pipeline: LSU state encoding and load type codes.
package xstage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MRT_LB  = 3'd0;
  localparam logic [2:0] MRT_LH  = 3'd1;
  localparam logic [2:0] MRT_LW  = 3'd2;
  localparam logic [2:0] MRT_LBU = 3'd4;
  localparam logic [2:0] MRT_LHU = 3'd5;

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte lane of a 64-bit read beat down to bit 0 and applies the
// sign/zero extension selected by the load type.
module load_align
  import xstage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  lane,
  input  logic [2:0]  rtype,
  output logic [31:0] data
);

  logic [63:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    data = shifted[31:0];
    case (rtype)
      MRT_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      MRT_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
      MRT_LBU: data = {24'b0, shifted[7:0]};
      MRT_LHU: data = {16'b0, shifted[15:0]};
      default: data = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/mstage_lsu.sv
// M-stage load/store unit: captures one X-stage bundle, performs at most one memory
// access over a valid/ready request channel, and presents the writeback result.
module mstage_lsu
  import xstage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] alu_res,
  input  logic [31:0] wdata,
  input  logic        mvalid,
  input  logic        mwen,
  input  logic [7:0]  mwmask,
  input  logic [2:0]  mrtype,
  input  logic [4:0]  rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] res_out,
  output logic [4:0]  rd_out
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mwen_q, mwen_d;
  logic [7:0]  mwmask_q, mwmask_d;
  logic [2:0]  mrtype_q, mrtype_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic [2:0]  lane;
  logic [31:0] load_data;
  logic [31:0] done_res;
  logic [4:0]  done_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mwen_q   <= 1'b0;
      mwmask_q <= '0;
      mrtype_q <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mwen_q   <= mwen_d;
      mwmask_q <= mwmask_d;
      mrtype_q <= mrtype_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Request fields come straight from captured state, so they hold through any stall.
  assign lane      = addr_q[2:0];
  assign mem_addr  = addr_q;
  assign mem_wen   = mwen_q;
  assign mem_wmask = mwmask_q << lane;
  assign mem_wdata = {32'b0, wdata_q} << {lane, 3'b000};

  load_align u_load_align (
    .rdata (mem_rdata),
    .lane  (lane),
    .rtype (mrtype_q),
    .data  (load_data)
  );

  // Stores retire with no register write.
  assign done_res = mwen_q ? 32'b0 : load_data;
  assign done_rd  = mwen_q ? 5'b0  : rd_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mwen_d   = mwen_q;
    mwmask_d = mwmask_q;
    mrtype_d = mrtype_q;
    rd_d     = rd_q;
    res_d    = res_q;
    rd_out_d = rd_out_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          addr_d   = alu_res;
          wdata_d  = wdata;
          mwen_d   = mwen;
          mwmask_d = mwmask;
          mrtype_d = mrtype;
          rd_d     = rd;
          if (mvalid) begin
            state_d = ST_REQ;
          end else begin
            res_d    = alu_res;
            rd_out_d = rd;
            state_d  = ST_OUT;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            res_d    = done_res;
            rd_out_d = done_rd;
            state_d  = ST_OUT;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          res_d    = done_res;
          rd_out_d = done_rd;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready       = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign m_valid       = (state_q == ST_OUT);
  assign res_out       = res_q;
  assign rd_out        = rd_out_q;

endmodule
